fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmit stage that drains the byte FIFO and sends each entry as an 8N1 UART frame on a single line. It sits directly downstream of the FIFO. It watches the FIFO's empty flag, issues one-cycle read strobes, captures the read data and serialises it LSB-first at a fixed clocks-per-bit rate. It can also be used standalone from any source with the same empty/read-strobe interface.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per UART bit; legal range 2..65535.
- DATA_W, default 8: payload width per frame; the bench uses 8.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous and active-high.
- fifo_empty  input  1  FIFO empty flag; 1 means there is nothing to read.
- fifo_data  input  DATA_W  FIFO data_out; valid on the cycle after a read strobe.
- fifo_read_enable  output  1  one-cycle read strobe to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high whenever a frame is being fetched or transmitted.

## Operation
- State machine: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If fifo_empty=0, go to FETCH.
- FETCH:
  - fifo_read_enable=1 for exactly this cycle.
  - Always go to LATCH.
- LATCH:
  - Load shift register from fifo_data.
  - Clear bit index and baud counter.
  - Go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit.
  - Shift right at each bit boundary.
  - After DATA_W bits, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - At the end, go to FETCH if fifo_empty=0, else IDLE. This allows back-to-back frames with no idle bit.
- fifo_read_enable is a Moore output, high only in FETCH. Exactly one strobe is issued per frame, and the block never strobes while fifo_empty=1.
- fifo_empty and fifo_data are ignored outside IDLE, FETCH-entry decisions and LATCH. Changes in these inputs mid-frame have no effect.
- busy=1 in every state except IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - A bit boundary is the cycle where count==CLKS_PER_BIT-1.
- Bit index:
  - Width $clog2(DATA_W+1).
  - Counts 0..DATA_W-1 and is never compared beyond DATA_W-1.

## Timing
- Reset values: tx=1, busy=0, fifo_read_enable=0, state=IDLE, counters=0, shift register=0.
- Reset asserted mid-frame:
  - Outputs return to their reset values immediately (asynchronously).
  - The partially sent byte is dropped; it has already been popped from the FIFO.
  - After release, the block restarts from IDLE.
- tx is registered and changes on the same edge as the state register. There are no combinational glitches on the line.
- Latency from fifo_empty falling (sampled in IDLE) to tx falling is 3 clock edges: IDLE→FETCH, FETCH→LATCH, LATCH→START.
- Frame length from the first START cycle to the end of STOP is (DATA_W+2)·CLKS_PER_BIT cycles.
- Back-to-back frames: after the last STOP cycle there are two cycles (FETCH, LATCH) with tx=1 before the next start bit.

## Structure
- A shared package uart_pkg holds:
  - the state enum type uart_tx_state_t;
  - the default constants UART_CLKS_PER_BIT and UART_DATA_W.
- Sub-module uart_baud_counter:
  - Parameterised on CLKS_PER_BIT.
  - Inputs: clear, enable.
  - Output: bit_done pulse.
  - Instantiated once in fifo_uart_tx.

## Test plan
- Reset and empty FIFO:
  - Stimulus: rst pulse, fifo_empty=1 held for 200 cycles.
  - Required: tx=1, busy=0 and fifo_read_enable=0 throughout.
- Single byte, CLKS_PER_BIT=4:
  - Stimulus: 0xA5 in the FIFO.
  - Required: exactly one read strobe; tx 3 edges later reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; busy returns to 0 after 40 frame cycles.
- Back-to-back, CLKS_PER_BIT=4:
  - Stimulus: FIFO holds 0x00 then 0xFF.
  - Required: two strobes; the second strobe falls on the cycle after the first frame's STOP; second frame sends 0, eight 1s, 1; fifo_empty=1 thereafter gives IDLE.
- Mid-frame input noise:
  - Stimulus: toggle fifo_empty and change fifo_data during DATA of byte 0x3C.
  - Required: transmitted bits stay 0,0,1,1,1,1,0,0 and no extra strobe is issued.
- Reset mid-frame:
  - Stimulus: assert rst during bit 3 of 0x81.
  - Required: tx=1 and busy=0 in the same cycle; after release with fifo_empty=0, the next byte is fetched and sent in full.
- Full-depth drain with the FIFO model:
  - Stimulus: 7 bytes written, CLKS_PER_BIT=2.
  - Required: 7 frames with payloads matching write order; the FIFO ends empty with no read strobe while empty.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and default constants for the UART transmit stage
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - wrapping clocks-per-bit counter with a bit boundary pulse
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = enable && !clear && (cnt_q == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a byte FIFO and sends each entry as an 8N1 UART frame
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_W       = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_read_enable,
    output logic              tx,
    output logic              busy
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    uart_tx_state_t    state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nx;
    logic [IDX_W-1:0]  idx_q;
    logic              tx_q;
    logic              busy_q;
    logic              rd_q;
    logic              baud_clear;
    logic              baud_en;
    logic              bit_done;

    assign baud_clear = (state_q == ST_LATCH);
    assign baud_en    = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign shift_nx   = shift_q >> 1;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .enable  (baud_en),
        .bit_done(bit_done)
    );

    // Outputs are assigned from the destination state so they switch on the same edge as state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= ST_FETCH;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_LATCH;
                    rd_q    <= 1'b0;
                end
                ST_LATCH: begin
                    shift_q <= fifo_data;
                    idx_q   <= '0;
                    state_q <= ST_START;
                    tx_q    <= 1'b0;
                end
                ST_START: begin
                    if (bit_done) begin
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q <= shift_nx;
                            idx_q   <= idx_q + IDX_W'(1);
                            tx_q    <= shift_nx[0];
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        if (!fifo_empty) begin
                            state_q <= ST_FETCH;
                            rd_q    <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    rd_q    <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_read_enable = rd_q;
    assign tx               = tx_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed bench with FIFO model, UART receiver and byte scoreboard
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel;
    logic       noise_en;
    logic       noise_empty;
    logic [7:0] noise_data;
    logic       wr_en;
    logic [7:0] wr_data;

    logic       m_empty = 1'b1;
    logic [7:0] m_data = 8'h00;
    logic [7:0] mem_q[$];
    int         strobes = 0;
    int         bad_strobes = 0;

    logic       f_empty, empty1, empty2;
    logic [7:0] f_data;
    logic       rd1, rd2, tx1, tx2, busy1, busy2;
    logic       rd_sel, tx_sel, busy_sel;

    assign f_empty  = noise_en ? noise_empty : m_empty;
    assign f_data   = noise_en ? noise_data : m_data;
    assign empty1   = sel ? 1'b1 : f_empty;
    assign empty2   = sel ? f_empty : 1'b1;
    assign rd_sel   = sel ? rd2 : rd1;
    assign tx_sel   = sel ? tx2 : tx1;
    assign busy_sel = sel ? busy2 : busy1;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_data(f_data),
        .fifo_read_enable(rd1), .tx(tx1), .busy(busy1)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(2), .DATA_W(8)) dut2 (
        .clk(clk), .rst(rst), .fifo_empty(empty2), .fifo_data(f_data),
        .fifo_read_enable(rd2), .tx(tx2), .busy(busy2)
    );

    // Registered-output FIFO model: data_out is valid the cycle after a read strobe.
    always @(posedge clk) begin
        if (rd_sel === 1'b1) begin
            strobes = strobes + 1;
            if (mem_q.size() == 0) bad_strobes = bad_strobes + 1;
            else m_data <= mem_q.pop_front();
        end
        if (wr_en) mem_q.push_back(wr_data);
        m_empty <= (mem_q.size() == 0);
    end

    // UART receiver: samples every cycle of a frame, flags any level change inside a bit.
    int         rx_wr = 0;
    logic [7:0] rx_byte [0:63];
    logic       rx_ok [0:63];
    int         rx_cpb;
    logic       rx_good, rx_lvl, rx_abort;
    logic [7:0] rx_b;

    always begin
        @(negedge clk);
        if (rst === 1'b0 && tx_sel === 1'b0) begin
            rx_cpb = sel ? 2 : 4;
            rx_good = 1'b1;
            rx_abort = 1'b0;
            rx_b = 8'h00;
            rx_lvl = 1'b0;
            for (int bi = 0; bi < 10 && !rx_abort; bi++) begin
                for (int c = 0; c < rx_cpb && !rx_abort; c++) begin
                    if (!(bi == 0 && c == 0)) @(negedge clk);
                    if (rst !== 1'b0) rx_abort = 1'b1;
                    else if (c == 0) rx_lvl = tx_sel;
                    else if (tx_sel !== rx_lvl) rx_good = 1'b0;
                end
                if (bi == 0 && rx_lvl !== 1'b0) rx_good = 1'b0;
                if (bi == 9 && rx_lvl !== 1'b1) rx_good = 1'b0;
                if (bi >= 1 && bi <= 8) rx_b = {rx_lvl, rx_b[7:1]};
            end
            if (!rx_abort) begin
                rx_byte[rx_wr] = rx_b;
                rx_ok[rx_wr] = rx_good;
                rx_wr = rx_wr + 1;
            end
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         rx_rd = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d, input logic expect_out);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = d;
        if (expect_out) exp_q.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_tx_low(output int n);
        n = 0;
        while (tx_sel !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_fall_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic drain_sb(input int cnt, input string tag);
        int t;
        logic [7:0] e;
        t = 0;
        while (rx_wr < rx_rd + cnt && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_rx_timeout"}, 32'(t < 3000), 32'd1);
        for (int k = 0; k < cnt && rx_rd < rx_wr; k++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            check({tag, "_byte"}, 32'(rx_byte[rx_rd]), 32'(e));
            check({tag, "_framing"}, 32'(rx_ok[rx_rd]), 32'd1);
            rx_rd++;
        end
    endtask

    initial begin
        int n;
        int s0;
        int bad;
        rst = 1'b1;
        sel = 1'b0;
        noise_en = 1'b0;
        noise_empty = 1'b1;
        noise_data = 8'h00;
        wr_en = 1'b0;
        wr_data = 8'h00;
        tick(3);
        check("reset_tx4", 32'(tx1), 32'd1);
        check("reset_busy4", 32'(busy1), 32'd0);
        check("reset_rd4", 32'(rd1), 32'd0);
        check("reset_tx2", 32'(tx2), 32'd1);
        check("reset_busy2", 32'(busy2), 32'd0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || rd1 !== 1'b0) bad++;
        end
        check("idle_empty_hold", 32'(bad), 32'd0);

        s0 = strobes;
        push(8'hA5, 1'b1);
        wait_tx_low(n);
        check("a5_latency", 32'(n), 32'd3);
        tick(39);
        check("a5_busy_last_stop", 32'(busy1), 32'd1);
        check("a5_tx_stop", 32'(tx1), 32'd1);
        tick(1);
        check("a5_busy_done", 32'(busy1), 32'd0);
        drain_sb(1, "a5");
        check("a5_strobes", 32'(strobes - s0), 32'd1);

        s0 = strobes;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h00; exp_q.push_back(8'h00);
        @(negedge clk);
        wr_data = 8'hFF; exp_q.push_back(8'hFF);
        @(negedge clk);
        wr_en = 1'b0;
        wait_tx_low(n);
        check("b2b_latency", 32'(n), 32'd2);
        tick(40);
        check("b2b_fetch_rd", 32'(rd1), 32'd1);
        check("b2b_fetch_tx", 32'(tx1), 32'd1);
        tick(1);
        check("b2b_latch_rd", 32'(rd1), 32'd0);
        check("b2b_latch_tx", 32'(tx1), 32'd1);
        tick(1);
        check("b2b_second_start", 32'(tx1), 32'd0);
        drain_sb(2, "b2b");
        tick(2);
        check("b2b_idle", 32'(busy1), 32'd0);
        check("b2b_strobes", 32'(strobes - s0), 32'd2);

        s0 = strobes;
        push(8'h3C, 1'b1);
        wait_tx_low(n);
        tick(8);
        noise_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            noise_empty = ~noise_empty;
            noise_data = 8'($urandom);
            tick(1);
        end
        noise_en = 1'b0;
        noise_empty = 1'b1;
        drain_sb(1, "noise");
        tick(2);
        check("noise_strobes", 32'(strobes - s0), 32'd1);
        check("noise_idle", 32'(busy1), 32'd0);

        s0 = strobes;
        push(8'h81, 1'b0);
        wait_tx_low(n);
        tick(18);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_tx", 32'(tx1), 32'd1);
        check("rst_mid_busy", 32'(busy1), 32'd0);
        check("rst_mid_rd", 32'(rd1), 32'd0);
        push(8'h5A, 1'b1);
        rst = 1'b0;
        wait_tx_low(n);
        drain_sb(1, "after_rst");
        check("rst_strobes", 32'(strobes - s0), 32'd2);

        tick(4);
        sel = 1'b1;
        s0 = strobes;
        bad = bad_strobes;
        @(negedge clk);
        wr_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_data = 8'($urandom);
            exp_q.push_back(wr_data);
            @(negedge clk);
        end
        wr_en = 1'b0;
        drain_sb(7, "drain");
        tick(3);
        check("drain_fifo_empty", 32'(m_empty), 32'd1);
        check("drain_strobes", 32'(strobes - s0), 32'd7);
        check("drain_no_empty_strobe", 32'(bad_strobes - bad), 32'd0);
        check("drain_idle", 32'(busy2), 32'd0);
        check("total_empty_strobes", 32'(bad_strobes), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
